// File: rtl/mem_master.sv
// mem_master: RAM port initiator for single-byte and burst reads and writes.
// Burst support is built only when MEM_MASTER_BURST_EN is defined.
module mem_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_write,
    input  logic              i_space,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [ADDR_W-1:0] i_length,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_wdataValid,
    output logic              o_wdataReady,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdataValid,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_addressEn,
    output logic [DATA_W-1:0] o_writeData,
    output logic              o_writeEn,
    output logic              o_readDataSelect,
    output logic              o_outEnable,
    input  logic [DATA_W-1:0] i_readData
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, space_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] count_load;
    logic              xfer, last;

`ifdef MEM_MASTER_BURST_EN
    assign count_load = i_length;
`else
    logic unused_length;
    assign unused_length = ^i_length;
    assign count_load    = '0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        count_d          = count_q;
        o_ready          = 1'b0;
        o_address        = '0;
        o_addressEn      = 1'b0;
        o_writeData      = '0;
        o_writeEn        = 1'b0;
        o_readDataSelect = 1'b0;
        o_outEnable      = 1'b0;
        o_wdataReady     = 1'b0;
        xfer             = 1'b0;
        last             = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                o_addressEn = 1'b1;
                o_address   = addr_q;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (write_q) begin
                    o_wdataReady = i_wdataValid;
                    xfer         = i_wdataValid;
                    if (i_wdataValid) begin
                        o_writeEn        = 1'b1;
                        o_writeData      = i_wdata;
                        o_readDataSelect = space_q;
                    end
                end else begin
                    o_outEnable      = 1'b1;
                    o_readDataSelect = space_q;
                    xfer             = 1'b1;
                end
                if (xfer) begin
                    if (count_q == '0) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end else begin
`ifdef MEM_MASTER_BURST_EN
                        // RAM still uses the old registered address this edge
                        addr_d      = addr_q + ADDR_W'(1);
                        count_d     = count_q - ADDR_W'(1);
                        o_addressEn = 1'b1;
                        o_address   = addr_d;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            space_q      <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
            o_rdata      <= '0;
            o_rdataValid <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_rdataValid <= 1'b0;
            o_done       <= last;
            if (state_q == IDLE && i_start) begin
                write_q <= i_write;
                space_q <= i_space;
                addr_q  <= i_address;
                count_q <= count_load;
            end else begin
                addr_q  <= addr_d;
                count_q <= count_d;
            end
            if (xfer && !write_q) begin
                o_rdata      <= i_readData;
                o_rdataValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed scoreboard bench for mem_master with a RAM model.
// Expectations follow MEM_MASTER_BURST_EN as seen by this compilation.
module tb_mem_master;

`ifdef MEM_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_write = 1'b0;
    logic       i_space = 1'b0;
    logic [7:0] i_address = '0;
    logic [7:0] i_length = '0;
    logic       o_ready;
    logic [7:0] i_wdata = '0;
    logic       i_wdataValid = 1'b0;
    logic       o_wdataReady;
    logic [7:0] o_rdata;
    logic       o_rdataValid;
    logic       o_done;
    logic [7:0] o_address;
    logic       o_addressEn;
    logic [7:0] o_writeData;
    logic       o_writeEn;
    logic       o_readDataSelect;
    logic       o_outEnable;
    logic [7:0] ram_rd;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] wbuf[256];
    logic [7:0] shadow[2][256];
    logic [7:0] pmem[256];
    logic [7:0] dmem[256];
    logic [7:0] areg = '0;

    always #5 i_clk = ~i_clk;

    mem_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_write(i_write),
        .i_space(i_space),
        .i_address(i_address),
        .i_length(i_length),
        .o_ready(o_ready),
        .i_wdata(i_wdata),
        .i_wdataValid(i_wdataValid),
        .o_wdataReady(o_wdataReady),
        .o_rdata(o_rdata),
        .o_rdataValid(o_rdataValid),
        .o_done(o_done),
        .o_address(o_address),
        .o_addressEn(o_addressEn),
        .o_writeData(o_writeData),
        .o_writeEn(o_writeEn),
        .o_readDataSelect(o_readDataSelect),
        .o_outEnable(o_outEnable),
        .i_readData(ram_rd)
    );

    // RAM: registered address, asynchronous read
    always @(posedge i_clk) begin
        if (o_addressEn) areg <= o_address;
        if (o_writeEn) begin
            if (o_readDataSelect) dmem[areg] <= o_writeData;
            else pmem[areg] <= o_writeData;
        end
    end
    assign ram_rd = !o_outEnable ? 8'h00 :
                    (o_readDataSelect ? dmem[areg] : pmem[areg]);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_done) done_cnt++;
        if (o_rdataValid) begin
            if (sb.size() == 0) chk("rd_unexpected", 32'(o_rdataValid), 32'd0);
            else chk("rdata", 32'(o_rdata), 32'(sb.pop_front()));
        end
    end

    task automatic idle_check(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge i_clk);
            chk("idle_strobes",
                32'({o_addressEn, o_writeEn, o_outEnable, o_ready}), 32'b0001);
        end
    endtask

    task automatic run_cmd(input bit w, input bit sp, input logic [7:0] a,
                           input logic [7:0] l, input int stall_at,
                           input int stall_n, input bit poke);
        int n, idx, cyc, stalled, aen, wen, done0, done_cyc;
        bit stall_now;
        logic [7:0] off;
        n = (BURST ? int'(l) : 0) + 1;
        for (int i = 0; i < n; i++) begin
            off = 8'(i);
            if (w) shadow[sp][a + off] = wbuf[i];
            else sb.push_back(shadow[sp][a + off]);
        end
        done0 = done_cnt;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_write = w; i_space = sp;
        i_address = a; i_length = l; i_wdataValid = 1'b0;
        idx = 0; stalled = 0; aen = 0; wen = 0; cyc = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 600) begin
            @(posedge i_clk); #1;
            cyc++;
            i_start = poke && cyc == 2;
            i_wdataValid = 1'b0;
            i_wdata = '0;
            stall_now = 1'b0;
            if (w && idx < n) begin
                if (cyc >= 2 && idx == stall_at && stalled < stall_n) begin
                    stalled++;
                    stall_now = 1'b1;
                end else begin
                    i_wdataValid = 1'b1;
                    i_wdata = wbuf[idx];
                end
            end
            @(negedge i_clk);
            if (cyc == 1) chk("busy_not_ready", 32'(o_ready), 32'd0);
            if (stall_now) chk("stall_strobes", 32'({o_writeEn, o_addressEn}), 32'd0);
            if (o_addressEn) begin
                off = 8'(aen);
                chk("address", 32'(o_address), 32'(a + off));
                aen++;
            end
            if (o_writeEn) begin
                chk("wdata", 32'(o_writeData), 32'(wbuf[idx]));
                chk("wr_space", 32'(o_readDataSelect), 32'(sp));
                wen++;
            end
            if (o_outEnable) chk("rd_space", 32'(o_readDataSelect), 32'(sp));
            if (o_wdataReady) idx++;
            if (o_done) begin
                done_cyc = cyc;
                chk("ready_with_done", 32'(o_ready), 32'd1);
            end
        end
        i_start = 1'b0;
        i_wdataValid = 1'b0;
        chk("done_latency", 32'(done_cyc), 32'(n + 2 + stalled));
        chk("addr_strobes", 32'(aen), 32'(n));
        chk("write_strobes", 32'(wen), w ? 32'(n) : 32'd0);
        idle_check(2);
        chk("done_count", 32'(done_cnt - done0), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int done0;
        for (int i = 0; i < 256; i++) begin
            pmem[i] = 8'(i) ^ 8'h5A;
            dmem[i] = ~8'(i);
            shadow[0][i] = 8'(i) ^ 8'h5A;
            shadow[1][i] = ~8'(i);
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_strobes", 32'({o_addressEn, o_writeEn, o_outEnable,
            o_readDataSelect, o_wdataReady, o_rdataValid, o_done}), 32'd0);
        chk("reset_buses", 32'({o_address, o_writeData, o_rdata}), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        wbuf[0] = 8'hA5;
        run_cmd(1'b1, 1'b1, 8'h10, 8'd0, -1, 0, 1'b0);
        run_cmd(1'b0, 1'b1, 8'h10, 8'd0, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        run_cmd(1'b1, 1'b0, 8'hFE, 8'd3, -1, 0, 1'b0);
        run_cmd(1'b0, 1'b0, 8'hFE, 8'd3, -1, 0, 1'b0);

        for (int i = 0; i < 6; i++) wbuf[i] = 8'hC0 + 8'(i);
        run_cmd(1'b1, 1'b1, 8'h40, 8'd5, 2, 2, 1'b0);
        run_cmd(1'b0, 1'b1, 8'h40, 8'd5, -1, 0, 1'b0);

        for (int i = 0; i < 3; i++) wbuf[i] = 8'h71 + 8'(i);
        run_cmd(1'b1, 1'b1, 8'h80, 8'd2, -1, 0, 1'b1);
        run_cmd(1'b0, 1'b1, 8'h80, 8'd2, -1, 0, 1'b1);

        done0 = done_cnt;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_write = 1'b0; i_space = 1'b1;
        i_address = 8'h30; i_length = 8'd15;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("rst_in_access", 32'(o_outEnable), 32'd1);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_strobes", 32'({o_addressEn, o_writeEn, o_outEnable,
            o_rdataValid, o_done}), 32'd0);
        idle_check(3);
        chk("rst_no_done", 32'(done_cnt - done0), 32'd0);

        run_cmd(1'b0, 1'b1, 8'h10, 8'd0, -1, 0, 1'b0);
        run_cmd(1'b0, 1'b0, 8'h20, 8'd7, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
